// File: rtl/branch_pkg.sv
// Shared constants for branch resolution: B-type funct3 codes
// and the flush FSM state encoding.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: funct3 plus comparator flags
// give the taken decision; reserved funct3 codes flag illegal.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       equal_i,
  input  logic       lt_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      BEQ:        taken_o = equal_i;
      BNE:        taken_o = ~equal_i;
      BLT, BLTU:  taken_o = lt_i;
      BGE, BGEU:  taken_o = ~lt_i;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with registered redirect and timed flush.
// Optional BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              is_branch_i,
  input  logic              is_jal_i,
  input  logic              is_jalr_i,
  input  logic [2:0]        funct3_i,
  input  logic              branch_equal_i,
  input  logic              branch_lt_i,
  output logic              cmp_is_unsigned,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic              pred_taken_i,
  input  logic [XLEN-1:0]   pred_target_i,
  output logic [XLEN-1:0]   link_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              flush_o,
  output logic              misalign_o,
  output logic              illegal_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [0:0]      state_q;
  logic [CW-1:0]   cnt_q;
  logic            cond_taken;
  logic            cond_illegal;
  logic            is_b;
  logic            taken;
  logic            illegal;
  logic            misalign;
  logic            mispred;
  logic            resolve;
  logic            do_redirect;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            flush_q;
  logic            misalign_q;
  logic            illegal_q;

  branch_cond_eval u_cond (
    .funct3_i  (funct3_i),
    .equal_i   (branch_equal_i),
    .lt_i      (branch_lt_i),
    .taken_o   (cond_taken),
    .illegal_o (cond_illegal)
  );

  assign cmp_is_unsigned = funct3_i[1];
  assign link_o          = pc_i + XLEN'(4);
  assign br_tgt          = pc_i + imm_i;
  assign jalr_tgt        = (rs1_i + imm_i) & ~XLEN'(1);

  // Overlapping type flags resolve as JALR > JAL > branch
  always_comb begin
    is_b   = 1'b0;
    taken  = 1'b0;
    target = br_tgt;
    if (is_jalr_i) begin
      taken  = 1'b1;
      target = jalr_tgt;
    end else if (is_jal_i) begin
      taken  = 1'b1;
    end else if (is_branch_i) begin
      is_b   = 1'b1;
      taken  = cond_taken;
    end
  end

  assign illegal  = is_b & cond_illegal;
  assign misalign = taken & (|target[1:0]);
  assign mispred  = (taken != pred_taken_i)
                  | (taken & (target != pred_target_i));
  assign resolve  = valid_i
                  & (is_branch_i | is_jal_i | is_jalr_i)
                  & (state_q == IDLE);
  assign do_redirect = resolve & mispred & ~misalign & ~illegal;
  assign next_pc     = taken ? target : link_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      redirect_q <= do_redirect;
      misalign_q <= resolve & misalign;
      illegal_q  <= resolve & illegal;
      if (do_redirect) redirect_pc_q <= next_pc;
      unique case (state_q)
        IDLE: begin
          if (do_redirect) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
            cnt_q   <= CW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign flush_o       = flush_q;
  assign misalign_o    = misalign_q;
  assign illegal_o     = illegal_q;

`ifdef BRU_STATS_EN
  logic [STAT_W-1:0] br_cnt_q;
  logic [STAT_W-1:0] mp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (resolve && !(&br_cnt_q))
        br_cnt_q <= br_cnt_q + STAT_W'(1);
      if (do_redirect && !(&mp_cnt_q))
        mp_cnt_q <= mp_cnt_q + STAT_W'(1);
    end
  end

  assign stat_branches_o = br_cnt_q;
  assign stat_mispred_o  = mp_cnt_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against
// a cycle-level behavioural model.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int SW   = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i, is_branch_i, is_jal_i, is_jalr_i;
  logic [2:0]      funct3_i;
  logic            branch_equal_i, branch_lt_i;
  logic            cmp_is_unsigned;
  logic [XLEN-1:0] pc_i, imm_i, rs1_i, pred_target_i;
  logic            pred_taken_i;
  logic [XLEN-1:0] link_o, redirect_pc_o;
  logic            redirect_o, flush_o, misalign_o, illegal_o;
  logic [SW-1:0]   stat_branches_o, stat_mispred_o;

  int checks   = 0;
  int failures = 0;
  int m_res    = 0;
  int m_mis    = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .STAT_W(SW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .is_branch_i     (is_branch_i),
    .is_jal_i        (is_jal_i),
    .is_jalr_i       (is_jalr_i),
    .funct3_i        (funct3_i),
    .branch_equal_i  (branch_equal_i),
    .branch_lt_i     (branch_lt_i),
    .cmp_is_unsigned (cmp_is_unsigned),
    .pc_i            (pc_i),
    .imm_i           (imm_i),
    .rs1_i           (rs1_i),
    .pred_taken_i    (pred_taken_i),
    .pred_target_i   (pred_target_i),
    .link_o          (link_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o),
    .illegal_o       (illegal_o),
    .stat_branches_o (stat_branches_o),
    .stat_mispred_o  (stat_mispred_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_i = 0; is_branch_i = 0; is_jal_i = 0; is_jalr_i = 0;
    funct3_i = 0; branch_equal_i = 0; branch_lt_i = 0;
    pc_i = 0; imm_i = 0; rs1_i = 0;
    pred_taken_i = 0; pred_target_i = 0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic eq,
                        input logic lt, input logic [31:0] pc,
                        input logic [31:0] imm, input logic pt,
                        input logic [31:0] ptg);
    idle_in();
    valid_i = 1; is_branch_i = 1; funct3_i = f3;
    branch_equal_i = eq; branch_lt_i = lt;
    pc_i = pc; imm_i = imm;
    pred_taken_i = pt; pred_target_i = ptg;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    m_res = 0;
    m_mis = 0;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 0;
    #3;
    checks++;
    if ({redirect_o, flush_o, misalign_o, illegal_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000",
               {redirect_o, flush_o, misalign_o, illegal_o});
    end
    checks++;
    if (redirect_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=0", redirect_pc_o);
    end
    checks++;
    if (stat_branches_o !== 0 || stat_mispred_o !== 0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0",
               stat_branches_o, stat_mispred_o);
    end
    do_reset();
  endtask

  task automatic test_beq();
    set_br(3'b000, 1, 0, 32'h100, 32'h20, 0, 0);
    tick();
    m_res++; m_mis++;
    checks++;
    if (redirect_o !== 1 || redirect_pc_o !== 32'h120 || flush_o !== 1) begin
      failures++;
      $display("FAIL beq_redirect got=%b %h %b exp=1 00000120 1",
               redirect_o, redirect_pc_o, flush_o);
    end
    idle_in();
    tick();
    checks++;
    if (redirect_o !== 0 || flush_o !== 1) begin
      failures++;
      $display("FAIL beq_flush2 got=%b %b exp=0 1", redirect_o, flush_o);
    end
    tick();
    checks++;
    if (flush_o !== 0) begin
      failures++;
      $display("FAIL beq_flush_end got=%b exp=0", flush_o);
    end
  endtask

  task automatic test_bltu();
    set_br(3'b100, 0, 1, 32'h200, 32'h40, 1, 32'h240);
    #1;
    checks++;
    if (cmp_is_unsigned !== 0) begin
      failures++;
      $display("FAIL blt_signed got=%b exp=0", cmp_is_unsigned);
    end
    set_br(3'b110, 0, 0, 32'h200, 32'h40, 0, 0);
    #1;
    checks++;
    if (cmp_is_unsigned !== 1) begin
      failures++;
      $display("FAIL bltu_unsigned got=%b exp=1", cmp_is_unsigned);
    end
    tick();
    m_res++;
    checks++;
    if (redirect_o !== 0 || flush_o !== 0) begin
      failures++;
      $display("FAIL bltu_notaken got=%b %b exp=0 0", redirect_o, flush_o);
    end
    idle_in();
    tick();
  endtask

  task automatic test_jalr();
    idle_in();
    valid_i = 1; is_jalr_i = 1; pc_i = 32'h300;
    rs1_i = 32'h1005; imm_i = 0;
    pred_taken_i = 1; pred_target_i = 32'h1004;
    #1;
    checks++;
    if (link_o !== 32'h304) begin
      failures++;
      $display("FAIL jalr_link got=%h exp=00000304", link_o);
    end
    tick();
    m_res++;
    checks++;
    if (redirect_o !== 0 || misalign_o !== 0) begin
      failures++;
      $display("FAIL jalr_correct got=%b %b exp=0 0", redirect_o, misalign_o);
    end
    // all type flags set with a reserved funct3: JALR must win
    is_jal_i = 1; is_branch_i = 1; funct3_i = 3'b010;
    pred_target_i = 32'h1000;
    tick();
    m_res++; m_mis++;
    checks++;
    if (redirect_o !== 1 || redirect_pc_o !== 32'h1004 || illegal_o !== 0) begin
      failures++;
      $display("FAIL jalr_prio got=%b %h %b exp=1 00001004 0",
               redirect_o, redirect_pc_o, illegal_o);
    end
    idle_in();
    tick();
    tick();
    valid_i = 1; is_jalr_i = 1; pc_i = 32'h300;
    rs1_i = 32'h1003; imm_i = 0;
    pred_taken_i = 1; pred_target_i = 32'h1000;
    tick();
    m_res++;
    checks++;
    if (misalign_o !== 1 || redirect_o !== 0 || flush_o !== 0) begin
      failures++;
      $display("FAIL jalr_misalign got=%b %b %b exp=1 0 0",
               misalign_o, redirect_o, flush_o);
    end
    idle_in();
    tick();
  endtask

  task automatic test_back_to_back();
    int nred;
    set_br(3'b000, 1, 0, 32'h400, 32'h80, 0, 0);
    tick();
    m_res++; m_mis++;
    nred = redirect_o ? 1 : 0;
    set_br(3'b001, 0, 0, 32'h500, 32'h100, 0, 0);
    tick();
    nred += redirect_o ? 1 : 0;
    checks++;
    if (flush_o !== 1 || redirect_pc_o !== 32'h480) begin
      failures++;
      $display("FAIL b2b_hold got=%b %h exp=1 00000480",
               flush_o, redirect_pc_o);
    end
    idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      nred += redirect_o ? 1 : 0;
    end
    checks++;
    if (nred != 1 || flush_o !== 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d flush=%b exp=1 flush=0", nred, flush_o);
    end
  endtask

  task automatic test_misalign_illegal();
    set_br(3'b001, 0, 0, 32'h100, 32'h2, 0, 0);
    tick();
    m_res++;
    checks++;
    if (misalign_o !== 1 || redirect_o !== 0 || flush_o !== 0) begin
      failures++;
      $display("FAIL bne_misalign got=%b %b %b exp=1 0 0",
               misalign_o, redirect_o, flush_o);
    end
    set_br(3'b010, 1, 1, 32'h100, 32'h10, 1, 32'h110);
    tick();
    m_res++;
    checks++;
    if (illegal_o !== 1 || misalign_o !== 0 || redirect_o !== 0
        || flush_o !== 0) begin
      failures++;
      $display("FAIL illegal_f3 got=%b %b %b %b exp=1 0 0 0",
               illegal_o, misalign_o, redirect_o, flush_o);
    end
    idle_in();
    tick();
    checks++;
    if (illegal_o !== 0 || misalign_o !== 0) begin
      failures++;
      $display("FAIL pulse_width got=%b %b exp=0 0", illegal_o, misalign_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    set_br(3'b000, 1, 0, 32'h600, 32'h40, 0, 0);
    tick();
    idle_in();
    rst_n = 0;
    #1;
    checks++;
    if (flush_o !== 0 || redirect_o !== 0 || redirect_pc_o !== 0) begin
      failures++;
      $display("FAIL rst_mid_flush got=%b %b %h exp=0 0 0",
               flush_o, redirect_o, redirect_pc_o);
    end
    tick();
    rst_n = 1;
    m_res = 0;
    m_mis = 0;
    tick();
    checks++;
    if (flush_o !== 0) begin
      failures++;
      $display("FAIL rst_release got=%b exp=0", flush_o);
    end
  endtask

  task automatic test_stats();
    int eb, em;
    do_reset();
    set_br(3'b000, 0, 0, 32'h0, 32'h40, 0, 0);
    tick();
    idle_in();
    valid_i = 1; is_jal_i = 1; pc_i = 32'h10; imm_i = 32'h40;
    pred_taken_i = 1; pred_target_i = 32'h50;
    tick();
    set_br(3'b001, 0, 0, 32'h20, 32'h8, 0, 0);
    tick();
    idle_in();
    tick(); tick(); tick();
`ifdef BRU_STATS_EN
    eb = 3; em = 1;
`else
    eb = 0; em = 0;
`endif
    checks++;
    if (stat_branches_o !== SW'(eb) || stat_mispred_o !== SW'(em)) begin
      failures++;
      $display("FAIL stats_3_1 got=%0d/%0d exp=%0d/%0d",
               stat_branches_o, stat_mispred_o, eb, em);
    end
    m_res = 3;
    m_mis = 1;
  endtask

  task automatic test_random();
    int flush_rem = 0;
    int kind;
    logic taken, resolve, e_mis, e_ill, e_red, e_flush, wrong;
    logic [31:0] tgt, e_pc, s;
    int eb, em;
    for (int n = 0; n < 400; n++) begin
      idle_in();
      valid_i        = ($urandom % 4) != 0;
      is_branch_i    = $urandom % 2;
      is_jal_i       = ($urandom % 4) == 0;
      is_jalr_i      = ($urandom % 4) == 0;
      funct3_i       = 3'($urandom % 8);
      branch_equal_i = $urandom % 2;
      branch_lt_i    = $urandom % 2;
      pc_i           = $urandom & 32'hffff_fffc;
      imm_i          = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'hffff_fffc);
      rs1_i          = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hffff_fffc);
      kind = is_jalr_i ? 2 : is_jal_i ? 1 : is_branch_i ? 0 : -1;
      if (kind == 2) begin
        s   = rs1_i + imm_i;
        tgt = s - (s % 2);
      end else begin
        tgt = pc_i + imm_i;
      end
      if (kind >= 1) taken = 1;
      else if (funct3_i == 0) taken = branch_equal_i;
      else if (funct3_i == 1) taken = !branch_equal_i;
      else if (funct3_i == 4 || funct3_i == 6) taken = branch_lt_i;
      else if (funct3_i == 5 || funct3_i == 7) taken = !branch_lt_i;
      else taken = 0;
      pred_taken_i  = ($urandom % 3 == 0) ? !taken : taken;
      pred_target_i = ($urandom % 3 == 0) ? ($urandom & 32'hffff_fffc) : tgt;
      #1;
      checks++;
      if (link_o !== pc_i + 32'd4 || cmp_is_unsigned !== (funct3_i >= 6 || funct3_i == 2 || funct3_i == 3)) begin
        failures++;
        $display("FAIL rnd_comb n=%0d got=%h %b", n, link_o, cmp_is_unsigned);
      end
      resolve = valid_i && kind >= 0 && flush_rem == 0;
      e_mis   = resolve && taken && (tgt % 4 != 0);
      e_ill   = resolve && kind == 0 && (funct3_i == 2 || funct3_i == 3);
      wrong   = (taken != pred_taken_i) || (taken && tgt != pred_target_i);
      e_red   = resolve && wrong && !e_mis && !e_ill;
      e_pc    = taken ? tgt : pc_i + 32'd4;
      if (resolve) m_res++;
      if (e_red) m_mis++;
      if (e_red) flush_rem = FC;
      else if (flush_rem > 0) flush_rem--;
      e_flush = flush_rem > 0;
      tick();
      checks++;
      if (redirect_o !== e_red || flush_o !== e_flush
          || misalign_o !== e_mis || illegal_o !== e_ill
          || (e_red && redirect_pc_o !== e_pc)) begin
        failures++;
        $display("FAIL rnd_seq n=%0d got=%b%b%b%b %h exp=%b%b%b%b %h",
                 n, redirect_o, flush_o, misalign_o, illegal_o,
                 redirect_pc_o, e_red, e_flush, e_mis, e_ill, e_pc);
      end
    end
`ifdef BRU_STATS_EN
    eb = m_res; em = m_mis;
`else
    eb = 0; em = 0;
`endif
    checks++;
    if (stat_branches_o !== SW'(eb) || stat_mispred_o !== SW'(em)) begin
      failures++;
      $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d",
               stat_branches_o, stat_mispred_o, eb, em);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltu();
    test_jalr();
    test_back_to_back();
    test_misalign_illegal();
    test_reset_mid_flush();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
